// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte sources share a single uart_tx.
// Define UART_ARB_WDOG_EN to compile in the per-byte done watchdog that drives timeout_err.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 200000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           tr_data,
  output logic                 send_en,
  input  logic                 done,
  output logic                 busy,
  output logic [2:0]           cur_id,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]           tr_data_q, tr_data_d;
  logic                 send_en_q, send_en_d;
  logic                 busy_q, busy_d;
  logic [2:0]           cur_id_q, cur_id_d;
  logic [2:0]           last_q, last_d;

  logic [2:0]           rot_amt_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [NUM_REQ-1:0]   low_s;
  logic [2:0]           pos_s;
  logic [3:0]           sum_s;
  logic [2:0]           win_id_s;
  logic                 any_req_s;

`ifdef UART_ARB_WDOG_EN
  logic [17:0]          wdog_q, wdog_d;
  logic                 timeout_q, timeout_d;
`endif

  // Rotate requests so the next-in-turn requester sits at bit 0, then take the lowest set bit.
  always_comb begin
    if (last_q == 3'(NUM_REQ - 1)) begin
      rot_amt_s = 3'd0;
    end else begin
      rot_amt_s = last_q + 3'd1;
    end
    rot_s = NUM_REQ'({req, req} >> rot_amt_s);
    low_s = rot_s & (~rot_s + NUM_REQ'(1));
    pos_s = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (low_s == (NUM_REQ'(1) << i)) begin
        pos_s = 3'(i);
      end else begin
        pos_s = pos_s;
      end
    end
    sum_s = {1'b0, rot_amt_s} + {1'b0, pos_s};
    if (sum_s >= 4'(NUM_REQ)) begin
      win_id_s = 3'(sum_s - 4'(NUM_REQ));
    end else begin
      win_id_s = sum_s[2:0];
    end
    any_req_s = |req;
  end

  // Next-state and next-output logic for the grant / start / wait / gap sequence.
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    send_en_d = 1'b0;
    tr_data_d = tr_data_q;
    cur_id_d  = cur_id_q;
    last_d    = last_q;
`ifdef UART_ARB_WDOG_EN
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d   = ST_LOAD;
          gnt_d     = NUM_REQ'(1) << win_id_s;
          tr_data_d = 8'(req_data >> {win_id_s, 3'b000});
          cur_id_d  = win_id_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d   = ST_WAIT;
        send_en_d = 1'b1;
`ifdef UART_ARB_WDOG_EN
        wdog_d    = 18'd0;
`endif
      end
      ST_WAIT: begin
        // done has priority over a watchdog expiry in the same cycle
        if (done) begin
          state_d = ST_GAP;
          last_d  = cur_id_q;
`ifdef UART_ARB_WDOG_EN
        end else if (wdog_q == 18'(WDOG_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          last_d    = cur_id_q;
        end else begin
          wdog_d = wdog_q + 18'd1;
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      tr_data_q <= 8'h00;
      send_en_q <= 1'b0;
      busy_q    <= 1'b0;
      cur_id_q  <= 3'd0;
      last_q    <= 3'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      tr_data_q <= tr_data_d;
      send_en_q <= send_en_d;
      busy_q    <= busy_d;
      cur_id_q  <= cur_id_d;
      last_q    <= last_d;
    end
  end

`ifdef UART_ARB_WDOG_EN
  // Watchdog counter and its expiry pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_q    <= 18'd0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign tr_data = tr_data_q;
  assign send_en = send_en_q;
  assign busy    = busy_q;
  assign cur_id  = cur_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: timing-rule reference model plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 50;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [7:0]     tr_data;
  logic           send_en;
  logic           done;
  logic           busy;
  logic [2:0]     cur_id;
  logic           timeout_err;

  int errors = 0;
  int checks = 0;
  int n_send = 0;
  int g_id[$];
  int g_dat[$];
  int exp_id[5]  = '{0, 1, 2, 3, 0};
  int exp_dat[5] = '{32'h41, 32'h42, 32'h43, 32'h44, 32'h41};
  int k;
  int n0;
  int s0;

  // expected outputs from the model
  logic [N-1:0] e_gnt;
  logic [7:0]   e_tr;
  logic         e_send;
  logic         e_busy;
  logic [2:0]   e_cur;
  logic         e_tmo;
  int           m_last;
  int           m_age;
  bit           m_active;
  bit           m_fin;

  uart_tx_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(W)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .tr_data(tr_data), .send_en(send_en), .done(done),
    .busy(busy), .cur_id(cur_id), .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin: first requesting index after 'last', wrapping around.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int j = 1; j <= N; j++) begin
      if (r[(last + j) % N]) return (last + j) % N;
    end
    return 0;
  endfunction

  // Model: a byte is granted, started one cycle later, then completes on done (plus one gap cycle)
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      e_gnt <= '0; e_tr <= 8'h00; e_send <= 1'b0; e_busy <= 1'b0; e_cur <= 3'd0; e_tmo <= 1'b0;
      m_last <= N - 1; m_age <= 0; m_active <= 1'b0; m_fin <= 1'b0;
    end else begin
      e_gnt <= '0; e_send <= 1'b0; e_tmo <= 1'b0;
      if (!m_active) begin
        if (req != '0) begin
          e_gnt    <= N'(1) << pick(req, m_last);
          e_tr     <= 8'(req_data >> (8 * pick(req, m_last)));
          e_cur    <= 3'(pick(req, m_last));
          e_busy   <= 1'b1;
          m_active <= 1'b1;
          m_age    <= 0;
          m_fin    <= 1'b0;
        end else begin
          e_busy <= 1'b0;
        end
      end else if (m_fin) begin
        m_active <= 1'b0;
        e_busy   <= 1'b0;
      end else if (m_age == 0) begin
        e_send <= 1'b1;
        m_age  <= 1;
      end else if (done) begin
        m_fin  <= 1'b1;
        m_last <= int'(e_cur);
`ifdef UART_ARB_WDOG_EN
      end else if (m_age == W) begin
        e_tmo    <= 1'b1;
        m_active <= 1'b0;
        e_busy   <= 1'b0;
        m_last   <= int'(e_cur);
`endif
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus grant/send logging.
  always @(negedge clock) begin
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("tr_data", 32'(tr_data), 32'(e_tr));
    check("send_en", 32'(send_en), 32'(e_send));
    check("busy", 32'(busy), 32'(e_busy));
    check("cur_id", 32'(cur_id), 32'(e_cur));
    check("timeout_err", 32'(timeout_err), 32'(e_tmo));
    if (gnt != '0) begin
      g_id.push_back(int'(cur_id));
      g_dat.push_back(int'(tr_data));
    end
    if (send_en) n_send++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Wait for the start pulse, let 'delay' cycles elapse, then return done.
  task automatic serve(input int delay);
    int c;
    c = 0;
    while (send_en !== 1'b1 && c < 20) begin
      tick(1);
      c++;
    end
    check("send_en_wait", 32'(c < 20), 32'd1);
    tick(delay);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check("busy_in_gap", 32'(busy), 32'd1);
    tick(1);
    check("busy_after_gap", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; req = '0; done = 1'b0; req_data = 32'h44434241;
    #1 reset = 1'b1;
    tick(2);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_send_en", 32'(send_en), 32'd0);
    check("rst_tr_data", 32'(tr_data), 32'h00);
    check("rst_cur_id", 32'(cur_id), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // done while idle is ignored
    tick(2); done = 1'b1; tick(1); done = 1'b0; tick(2);
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_send", 32'(n_send), 32'd0);

    // single requester, done after 100 cycles
    req = 4'b0001; tick(1);
    check("single_gnt", 32'(gnt), 32'b0001);
    check("single_tr", 32'(tr_data), 32'h41);
    serve(100); req = '0; tick(3);
    check("single_gnt_count", 32'(g_id.size()), 32'd1);
    check("single_send_count", 32'(n_send), 32'd1);

    // all four held: order 0,1,2,3,0
    pulse_reset();
    g_id.delete(); g_dat.delete();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) serve(3);
    req = '0; tick(2);
    check("rr_count", 32'(g_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < g_id.size(); i++) begin
      check("rr_id", 32'(g_id[i]), 32'(exp_id[i]));
      check("rr_data", 32'(g_dat[i]), 32'(exp_dat[i]));
    end

    // after serving 2, {0,2} requesting wraps to 0
    req = 4'b0100; serve(2); req = '0; tick(1);
    req = 4'b0101; tick(1);
    check("wrap_gnt", 32'(gnt), 32'b0001);
    check("wrap_id", 32'(cur_id), 32'd0);
    serve(2); req = '0; tick(1);

    // withdrawn request and post-grant data change have no effect
    n0 = g_id.size();
    req = 4'b1000; tick(1);
    check("wd_id", 32'(cur_id), 32'd3);
    req = 4'b0010; req_data[31:24] = 8'h99; tick(1);
    req = '0; serve(4); tick(2);
    check("wd_gnt_count", 32'(g_id.size()), 32'(n0 + 1));
    check("wd_tr_hold", 32'(tr_data), 32'h44);
    req_data[31:24] = 8'h44;

    // asynchronous reset mid-WAIT, then regrant of requester 1
    req = 4'b0010; tick(2);
    check("mid_send_en", 32'(send_en), 32'd1);
    tick(3);
    #2 reset = 1'b1;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_tr", 32'(tr_data), 32'd0);
    check("async_cur", 32'(cur_id), 32'd0);
    @(negedge clock); reset = 1'b0;
    n0 = g_id.size(); s0 = n_send;
    serve(3); req = '0; tick(1);
    check("regrant_id", 32'(cur_id), 32'd1);
    check("regrant_gnt_count", 32'(g_id.size()), 32'(n0 + 1));
    check("regrant_send_count", 32'(n_send), 32'(s0 + 1));

`ifdef UART_ARB_WDOG_EN
    // done never returns: expiry 50 cycles after WAIT entry, next requester follows
    pulse_reset();
    req = 4'b1100; tick(2);
    check("wdog_send_en", 32'(send_en), 32'd1);
    check("wdog_first_id", 32'(cur_id), 32'd2);
    k = 0;
    while (timeout_err !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    check("wdog_latency", 32'(k), 32'(W));
    tick(1);
    check("wdog_next_gnt", 32'(gnt), 32'b1000);
    req = '0;
    serve(2); tick(1);
`else
    // no watchdog: WAIT holds until done
    pulse_reset();
    req = 4'b0100; tick(2);
    check("nowdog_send_en", 32'(send_en), 32'd1);
    tick(60);
    check("nowdog_busy", 32'(busy), 32'd1);
    check("nowdog_cur", 32'(cur_id), 32'd2);
    req = '0;
    done = 1'b1; tick(1); done = 1'b0;
    check("nowdog_gap", 32'(busy), 32'd1);
    tick(1);
    check("nowdog_idle", 32'(busy), 32'd0);
`endif

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one uart_tx (2..8).
REQ-002 Parameter: WDOG_CYCLES, default 200000, maximum clock cycles to wait for done per byte.
REQ-003 Port: clock  in  1  system clock; all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  NUM_REQ  per-requester send request, level, held until granted.
REQ-006 Port: req_data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 Port: gnt  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
REQ-008 Port: tr_data  out  8  byte presented to uart_tx; stable from grant until return to IDLE.
REQ-009 Port: send_en  out  1  one-cycle start pulse to uart_tx.
REQ-010 Port: done  in  1  uart_tx completion pulse.
REQ-011 Port: busy  out  1  high in every state except IDLE.
REQ-012 Port: cur_id  out  3  index of the requester being served; holds last value in IDLE.
REQ-013 Port: timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 FSM states: IDLE, LOAD, WAIT, GAP; all outputs are registered.
REQ-015 IDLE with any req bit high: select winner, pulse gnt[winner], load tr_data from req_data[winner], set cur_id, go to LOAD at the same edge.
REQ-016 Winner: round-robin; search starts at (last_granted+1) mod NUM_REQ and wraps; after reset the search starts at 0.
REQ-017 LOAD: send_en=1 for exactly one cycle; go to WAIT; clear watchdog counter.
REQ-018 WAIT: on done=1, go to GAP; last_granted<=cur_id.
REQ-019 GAP: one idle cycle with busy=1; go to IDLE; no grant is issued in GAP.
REQ-020 Latency: req sampled high in IDLE at edge N -> gnt high after edge N; send_en high after edge N+1.
REQ-021 Back-to-back: minimum 3 cycles plus the uart_tx frame time between consecutive send_en pulses.
REQ-022 done in IDLE, LOAD or GAP is ignored.
REQ-023 A req dropped before grant is withdrawn with no side effect; req changes after grant do not affect tr_data.
REQ-024 Requesters not granted keep req high; no request is lost or duplicated; one gnt per byte.

Reset
REQ-025 reset=1 forces state IDLE, gnt=0, send_en=0, busy=0, tr_data=8'h00, cur_id=0, timeout_err=0, last_granted=NUM_REQ-1, and watchdog counter 0, independent of clock.
REQ-026 Reset mid-WAIT abandons the byte without a gnt re-issue; after release the arbiter resumes at IDLE.

Configuration
REQ-027 Macro UART_ARB_WDOG_EN compiles in the watchdog.
REQ-028 With the macro defined: an 18-bit counter increments each WAIT cycle; on reaching WDOG_CYCLES without done, pulse timeout_err, set last_granted<=cur_id, and go to IDLE.
REQ-029 Same-cycle done and expiry: done wins; no timeout_err.
REQ-030 Without the macro: no counter is present, timeout_err is tied to 0, and WAIT exits only on done.

Verification
REQ-031 req=4'b0001, data0=8'h41, done after 100 cycles -> gnt=0001 once, tr_data=41, single send_en, busy low 2 cycles after done.
REQ-032 req=4'b1111 held, data 41/42/43/44, done after each send -> grants in order 0,1,2,3, then 0 again; tr_data sequence 41,42,43,44.
REQ-033 After serving requester 2, req=4'b0101 -> requester 0 is granted next (wrap from 3 to 0).
REQ-034 With UART_ARB_WDOG_EN and WDOG_CYCLES=50, done never returns -> timeout_err pulse exactly 50 cycles after WAIT entry, then IDLE, and the next requester is granted.
REQ-035 Reset asserted mid-WAIT with req=4'b0010 held -> outputs zero asynchronously; after release requester 1 is regranted with a fresh send_en.
REQ-036 done pulse while IDLE with no req -> no state change and no send_en.
